// File: rtl/matrix_row_scanner.sv
// Row-multiplexed 8x16 LED matrix scanner: shifts each row word out serially, latches it, then lights the row.
// Optional MATRIX_ROW_SCANNER_BLANK_EN blanks row_sel during LATCH and lights the new row on the first HOLD cycle.
module matrix_row_scanner #(
   parameter int CLK_DIV  = 4,
   parameter int ROW_HOLD = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] frame_i,
   output logic         frame_ack,
   output logic         sclk,
   output logic         sdata,
   output logic         latch,
   output logic [7:0]   row_sel
);

   localparam int DIV_W  = $clog2(CLK_DIV + 1);
   localparam int HOLD_W = $clog2(ROW_HOLD + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SHIFT,
      S_LATCH,
      S_HOLD
   } state_t;

   state_t              state, state_n;
   logic [DIV_W-1:0]    div_cnt, div_cnt_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
   logic [4:0]          bit_cnt, bit_cnt_n;
   logic [2:0]          row, row_n;
   logic [127:0]        frame_buf, frame_buf_n;
   logic [15:0]         shreg, shreg_n;
   logic                sclk_n, latch_n, frame_ack_n;
   logic [7:0]          row_sel_n;
   logic [7:0]          row_onehot;
   logic [15:0]         row_word;

   assign row_onehot = 8'd1 << row;
   // Row r occupies bits 127-16r down; that top index is {7-r, 4'hF} == {~r, 4'hF}.
   assign row_word   = frame_buf[{~row, 4'hF} -: 16];
   assign sdata      = shreg[15];

   always_comb begin
      state_n     = state;
      div_cnt_n   = div_cnt;
      hold_cnt_n  = hold_cnt;
      bit_cnt_n   = bit_cnt;
      row_n       = row;
      frame_buf_n = frame_buf;
      shreg_n     = shreg;
      sclk_n      = sclk;
      latch_n     = latch;
      row_sel_n   = row_sel;
      frame_ack_n = 1'b0;

      case (state)
         S_LOAD: begin
            if (row == 3'd0) begin
               frame_buf_n = frame_i;
               frame_ack_n = 1'b1;
               shreg_n     = frame_i[127:112];
            end else begin
               shreg_n = row_word;
            end
            div_cnt_n = '0;
            bit_cnt_n = '0;
            sclk_n    = 1'b0;
            state_n   = S_SHIFT;
         end

         S_SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               if (!sclk) begin
                  sclk_n = 1'b1;
               end else begin
                  sclk_n = 1'b0;
                  if (bit_cnt == 5'd15) begin
                     latch_n = 1'b1;
                     state_n = S_LATCH;
`ifdef MATRIX_ROW_SCANNER_BLANK_EN
                     row_sel_n = '0;
`else
                     row_sel_n = row_onehot;
`endif
                  end else begin
                     bit_cnt_n = bit_cnt + 5'd1;
                     shreg_n   = {shreg[14:0], 1'b0};
                  end
               end
            end else begin
               div_cnt_n = div_cnt + 1'b1;
            end
         end

         S_LATCH: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n  = '0;
               hold_cnt_n = '0;
               latch_n    = 1'b0;
               state_n    = S_HOLD;
`ifdef MATRIX_ROW_SCANNER_BLANK_EN
               row_sel_n  = row_onehot;
`endif
            end else begin
               div_cnt_n = div_cnt + 1'b1;
            end
         end

         S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_cnt_n = '0;
               row_n      = row + 3'd1;
               state_n    = S_LOAD;
            end else begin
               hold_cnt_n = hold_cnt + 1'b1;
            end
         end

         default: state_n = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_LOAD;
         div_cnt   <= '0;
         hold_cnt  <= '0;
         bit_cnt   <= '0;
         row       <= '0;
         frame_buf <= '0;
         shreg     <= '0;
         sclk      <= 1'b0;
         latch     <= 1'b0;
         row_sel   <= '0;
         frame_ack <= 1'b0;
      end else begin
         state     <= state_n;
         div_cnt   <= div_cnt_n;
         hold_cnt  <= hold_cnt_n;
         bit_cnt   <= bit_cnt_n;
         row       <= row_n;
         frame_buf <= frame_buf_n;
         shreg     <= shreg_n;
         sclk      <= sclk_n;
         latch     <= latch_n;
         row_sel   <= row_sel_n;
         frame_ack <= frame_ack_n;
      end
   end

endmodule

// File: doc/matrix_row_scanner.md
# matrix_row_scanner

Consumes the 128-bit 8×16 display frame produced by the digit-to-bitmap stage and drives a row-multiplexed LED matrix. Column data goes out through an external serial shift-register chain, and rows are selected one-hot. The frame is sampled only at the start of each scan so a refresh never mixes two frames. The block sits between the time-to-bitmap logic and the board's matrix driver pins.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per sclk half-period; must be ≥1.
- ROW_HOLD, 1024: clocks a row stays lit after its latch; must be ≥1.

Ports:
- clk, input, 1: system clock; everything is on the rising edge.
- rst_n, input, 1: **synchronous reset, active-low.**
- frame_i, input, 128: bitmap frame.
  - Row r is frame_i[127-16r -: 16].
  - Within a row word, bit 15 is column 0 (leftmost).
- frame_ack, output, 1: one-cycle pulse when frame_i is sampled.
- sclk, output, 1: shift clock to the column registers.
- sdata, output, 1: serial column data, valid on the sclk rising edge.
- latch, output, 1: storage-register latch pulse.
- row_sel, output, 8: one-hot row drive, active-high; bit r = row r.

## Operation
State machine: LOAD → SHIFT → LATCH → HOLD → LOAD.

LOAD (1 cycle):
- If row == 0: copy frame_i into frame_buf and pulse frame_ack.
- Load the 16-bit shift register with row word `row` from frame_buf. For row 0, use the freshly sampled frame_i value.
- Go to SHIFT.

SHIFT (16 bits, MSB first):
- Per bit, sdata holds the current MSB for 2·CLK_DIV cycles.
- sclk is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles.
- The shift register shifts left when sclk falls back to 0.
- After the 16th high phase: sclk=0, go to LATCH.

LATCH (CLK_DIV cycles):
- latch=1.
- row_sel = one-hot(row) from the first LATCH cycle.

HOLD (ROW_HOLD cycles):
- latch=0; row_sel unchanged.
- On exit: row ← row+1 mod 8 (7 wraps to 0), go to LOAD.

General rules:
- The displayed row keeps its previous row_sel through LOAD and SHIFT. The column registers are not updated until the latch, so there is no visible glitch.
- frame_i changes outside the row-0 LOAD cycle are ignored until the next frame.

Reset (rst_n=0 at a clock edge):
- state=LOAD, row=0, frame_buf=0, shift register=0.
- sclk=0, sdata=0, latch=0, row_sel=8'h00, frame_ack=0.
- Reset asserted mid-operation aborts the current row at that edge.
- The first LOAD after release is the first cycle with rst_n=1 and samples a new frame.

Counter widths:
- Divider counter: $clog2(CLK_DIV+1) bits.
- Hold counter: $clog2(ROW_HOLD+1) bits.
- Bit counter: 5 bits. Row counter: 3 bits.
- No overflow is possible within the legal parameter range.

## Timing
- Row period = 1 + 32·CLK_DIV + CLK_DIV + ROW_HOLD cycles. With defaults: 1+128+4+1024 = 1157.
- Frame period = 8 × row period; frame_ack occurs once per frame period.
- First sclk rise: 1+CLK_DIV cycles after LOAD.
- Column data latched onto the pins: 1+32·CLK_DIV cycles after LOAD.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
Macro MATRIX_ROW_SCANNER_BLANK_EN:
- **Defined:** row_sel is forced to 8'h00 during the whole LATCH state, and one-hot(row) is asserted on the first HOLD cycle. This prevents ghosting while the storage registers update. Lit time per row is unchanged (ROW_HOLD).
- **Undefined:** row_sel switches to the new row on the first LATCH cycle, as described in Operation.

## Test plan
- **Row 0 serial data.**
  - Stimulus: reset, CLK_DIV=1, ROW_HOLD=4, frame_i[127:112]=16'hE0A0, rest 0.
  - Required: sdata sampled at sclk rises = 1,1,1,0,0,0,0,0,1,0,1,0,0,0,0,0; latch high 1 cycle; row_sel=8'h01.
- **Row period and sequence.**
  - Stimulus: CLK_DIV=2, ROW_HOLD=8.
  - Required: successive LOAD cycles exactly 75 cycles apart; row_sel steps 01,02,04,…,80,01; frame_ack pulses every 600 cycles.
- **Frame isolation.**
  - Stimulus: change frame_i from all-ones to all-zeros during row 3 SHIFT.
  - Required: rows 3–7 still shift 16'hFFFF; the next row 0 shifts 16'h0000, coinciding with a frame_ack pulse.
- **Mid-shift reset.**
  - Stimulus: assert rst_n=0 for 1 cycle during bit 7 of row 5.
  - Required: next edge gives sclk=0, latch=0, row_sel=00. Restart at row 0 with frame_ack on the first cycle with rst_n=1.
- **Blank enabled.**
  - Stimulus: define MATRIX_ROW_SCANNER_BLANK_EN, CLK_DIV=3.
  - Required: row_sel=00 for exactly 3 cycles while latch=1, then one-hot(row) for ROW_HOLD cycles.
- **Minimum parameters.**
  - Stimulus: CLK_DIV=1, ROW_HOLD=1.
  - Required: row period = 35 cycles; no missed or extra sclk edges (exactly 16 rises per row).
